status_output_sequencer: RTL
============================

Name: status_output_sequencer

Overview:
- Owns the 32-bit output stream of the mode controller.
- Forwards datapath output words, then appends exactly one status word per operation. The status word carries SUCCESS (4'b1110) or FAILURE (4'b1111) in the top nibble, with zeros below.
- Sits between the mode FSM / datapath and the output FIFO. Enforces that status is never emitted ahead of, or interleaved with, the data of its operation.

Parameters:
- DW, 32, output word width; must be >= 4; status code occupies bits [DW-1:DW-4].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  DW  datapath output word
- din_valid  in  1  din is valid
- din_last  in  1  din is the final data word of the operation
- din_ready  out  1  sequencer accepts din this cycle
- st_valid  in  1  mode FSM presents the operation result
- st_fail  in  1  1 = FAILURE, 0 = SUCCESS; qualified by st_valid
- st_ready  out  1  result accepted
- dout  out  DW  output word
- dout_valid  out  1  dout is valid
- dout_last  out  1  dout is the status word
- dout_ready  in  1  downstream accepts dout
- busy  out  1  operation in progress (state != IDLE or dout_valid)

Behaviour:
- Reset (async assert, sync release): state=IDLE; dout=0; dout_valid=0; dout_last=0; din_ready=0 until the first clk edge after release; busy=0.
- Single output register. A handshake is valid&&ready on a rising edge. Output register may load when (!dout_valid || dout_ready), giving one word/cycle throughput and 1-cycle latency din->dout.
- dout, dout_last are held stable while dout_valid && !dout_ready; dout_valid never drops without a handshake.
- FSM states:
  - IDLE: din_ready = load_ok; st_ready = load_ok.
    - din handshake -> DATA, or -> WAIT_ST if din_last.
    - st handshake (no din accepted this cycle) -> STATUS. This covers an operation with no output data, e.g. decryption tag failure.
    - If din_valid and st_valid are both set, din wins; st_ready=0 that cycle.
  - DATA: din_ready = load_ok; st_ready=0. A din handshake with din_last -> WAIT_ST.
  - WAIT_ST: din_ready=0; st_ready = load_ok. On st handshake, load the status word, dout_last=1 -> STATUS.
  - STATUS: din_ready=0; st_ready=0. On dout handshake of the status word -> IDLE. The next operation's din may be accepted the same cycle the status word leaves only if already back in IDLE (i.e. from the next cycle).
- Status word = {st_fail ? 4'b1111 : 4'b1110, (DW-4)'b0}, latched at st handshake.
- st_fail is ignored unless st_valid.
- Reset mid-operation discards any held word and returns to IDLE; no partial status is emitted.
- st_valid asserted in DATA is legal. It is held off (st_ready=0) until last data is accepted.

Optional Feature:
- Macro: STATUS_FAIL_CNT_EN.
- Defined:
  - Extra output port fail_cnt [15:0], reset 0.
  - Increments by 1 on each FAILURE status handshake at dout; saturates at 16'hFFFF.
  - Extra input fail_cnt_clr (sync clear, priority over increment).
- Undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- Shared package status_pkg:
  - localparams STATUS_SUCCESS=4'b1110, STATUS_FAILURE=4'b1111.
  - FSM state encoding IDLE/DATA/WAIT_ST/STATUS (2 bits).
- Existing status_encoder is instantiated as the sole sub-module to build the status word; the sequencer itself stays flat otherwise.

Test Plan:
- 3 data words (0x11111111, 0x22222222, 0x33333333 last) then st_valid, st_fail=0, dout_ready=1 -> dout sequence: the three words, then 0xE0000000 with dout_last=1; busy falls the cycle after.
- st_valid, st_fail=1 in IDLE, no data -> single dout 0xF0000000, dout_last=1; din_ready=0 while in STATUS.
- Same stream with dout_ready toggling 1,0,0,1... -> no word lost or duplicated; dout stable while stalled.
- st_valid asserted during DATA before last word -> st_ready=0 until last word accepted; status strictly follows data.
- din_valid and st_valid simultaneous in IDLE -> din accepted, st_ready=0; status emitted after din_last.
- rst_n pulsed low while status held with dout_ready=0 -> dout_valid=0 immediately (async); no status emitted after release. With STATUS_FAIL_CNT_EN: 2 FAILURE operations -> fail_cnt=2; fail_cnt_clr -> 0.

Source files
------------

// File: rtl/status_pkg.sv
// Shared status codes and sequencer state encoding for the mode controller output path.
// The status nibble occupies the top four bits of every status word.
package status_pkg;

    localparam logic [3:0] STATUS_SUCCESS = 4'b1110;
    localparam logic [3:0] STATUS_FAILURE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        WAIT_ST = 2'd2,
        STATUS  = 2'd3
    } seq_state_e;

    function automatic logic [3:0] status_code(input logic fail);
        return fail ? STATUS_FAILURE : STATUS_SUCCESS;
    endfunction

endpackage

// File: rtl/status_encoder.sv
// Builds a status word: result code in the top nibble, zeros below.
// Latency: combinational. Backpressure: none (pure function of fail_i).
// Any latching of the word is left to the caller.
module status_encoder
    import status_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          fail_i,
    output logic [DW-1:0] word_o
);

    assign word_o = {status_code(fail_i), {(DW-4){1'b0}}};

endmodule

// File: rtl/status_output_sequencer.sv
// Forwards operation data words, then appends exactly one status word per operation.
// Latency: 1 cycle din->dout and st->dout, one word per cycle through a single output register.
// Backpressure: din_ready/st_ready follow the output register's load_ok; dout is held while stalled.
// Optional fail counter: define STATUS_FAIL_CNT_EN.
module status_output_sequencer
    import status_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_last,
    output logic          din_ready,
    input  logic          st_valid,
    input  logic          st_fail,
    output logic          st_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_last,
    input  logic          dout_ready,
`ifdef STATUS_FAIL_CNT_EN
    input  logic          fail_cnt_clr,
    output logic [15:0]   fail_cnt,
`endif
    output logic          busy
);

    seq_state_e    state_q, state_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q, dout_last_d;
    logic          rdy_en_q;
    logic          load_ok;
    logic          din_ready_c;
    logic          st_ready_c;
    logic [DW-1:0] status_word;

    status_encoder #(.DW(DW)) u_status_encoder (
        .fail_i (st_fail),
        .word_o (status_word)
    );

    assign load_ok = !dout_valid_q || dout_ready;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        dout_last_d  = dout_last_q;
        din_ready_c  = 1'b0;
        st_ready_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                din_ready_c = rdy_en_q && load_ok;
                // Data takes priority so a result can never overtake its own data.
                st_ready_c  = rdy_en_q && load_ok && !din_valid;
                if (din_valid && din_ready_c) begin
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b0;
                    state_d      = din_last ? WAIT_ST : DATA;
                end else if (st_valid && st_ready_c) begin
                    dout_d       = status_word;
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b1;
                    state_d      = STATUS;
                end
            end
            DATA: begin
                din_ready_c = rdy_en_q && load_ok;
                if (din_valid && din_ready_c) begin
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b0;
                    if (din_last) begin
                        state_d = WAIT_ST;
                    end
                end
            end
            WAIT_ST: begin
                st_ready_c = rdy_en_q && load_ok;
                if (st_valid && st_ready_c) begin
                    dout_d       = status_word;
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b1;
                    state_d      = STATUS;
                end
            end
            STATUS: begin
                if (dout_valid_q && dout_ready && dout_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign din_ready  = din_ready_c;
    assign st_ready   = st_ready_c;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = (state_q != IDLE) || dout_valid_q;

`ifdef STATUS_FAIL_CNT_EN
    logic [15:0] fail_cnt_q;
    logic        fail_hs;

    assign fail_hs = dout_valid_q && dout_ready && dout_last_q
                     && (dout_q[DW-1 -: 4] == STATUS_FAILURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q <= 16'h0000;
        end else if (fail_cnt_clr) begin
            fail_cnt_q <= 16'h0000;
        end else if (fail_hs && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_q <= fail_cnt_q + 16'h0001;
        end
    end

    assign fail_cnt = fail_cnt_q;
`endif

endmodule
